// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instr, pc} entries with flush; shows a NOP head when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_en;
    logic           pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_en  = pop & ~empty & ~flush;
    // Push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_en = push & ~flush & (~full | pop_en);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

    // NOTE: storage is not reset; validity lives in count, and the empty head is masked below.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wr_entry;
    end

    assign head = empty ? EMPTY_ENTRY : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem requester, buffered valid/ready output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   addr_next;
    logic [31:0]   redirect_aligned;
    logic          req_next;
    logic          ack;
    logic          push;
    logic          pop;
    logic          pop_eff;
    logic          push_eff;
    logic          room;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    assign redirect_aligned = redirect_pc & ~32'h3;
    assign ack              = imem_req & imem_ack;
    assign pop              = instr_valid & instr_ready;
    assign wr_entry         = '{instr: imem_rdata, pc: imem_addr};

    // Occupancy after this edge decides whether a new request may start now.
    assign pop_eff     = pop & ~empty;
    assign push_eff    = push & (~full | pop_eff);
    assign count_after = redirect_valid ? '0 : count + CW'(push_eff) - CW'(pop_eff);
    assign room        = count_after < CW'(FIFO_DEPTH);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = imem_addr;
        req_next      = imem_req;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    state_next    = BUSY;
                    fetch_pc_next = redirect_aligned;
                    addr_next     = redirect_aligned;
                    req_next      = 1'b1;
                end else if (room) begin
                    state_next = BUSY;
                    addr_next  = fetch_pc;
                    req_next   = 1'b1;
                end
            end
            BUSY: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_aligned;
                    if (ack) addr_next = redirect_aligned;
                    else     state_next = DROP;
                end else if (ack) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + PC_STEP;
                    if (room) begin
                        addr_next = fetch_pc + PC_STEP;
                    end else begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end
            end
            DROP: begin
                // The stale request must still complete before the redirected one can start.
                if (redirect_valid) fetch_pc_next = redirect_aligned;
                if (ack) begin
                    state_next = BUSY;
                    addr_next  = redirect_valid ? redirect_aligned : fetch_pc;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_addr <= addr_next;
            imem_req  <= req_next;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_entry(wr_entry),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign instr_valid = ~empty;
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table, memory model with wait states, PC scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int          checks = 0;
    int          errors = 0;
    int          wait_states = 0;
    int          wcnt = 0;
    bit          mem_stall = 1'b0;
    logic [31:0] sb_q[$];

    typedef struct {
        bit          new_reset;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } row_t;

    row_t tbl [12];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        mem_stall      = 1'b0;
        sb_q.delete();
        instr_ready    = rdy;
        #1;
        check("rst_req",   32'(imem_req), 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr_out, 32'h0000_0013);
        check("rst_pc",    instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'h0);
    endtask

    // Memory responder: acks after wait_states idle cycles of a request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !imem_req) begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end else if (mem_stall) begin
                imem_ack = 1'b0;
            end else if (wcnt >= wait_states) begin
                imem_ack = 1'b1;
                wcnt     = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
            imem_rdata = mem_word(imem_addr);
        end
    end

    // Scoreboard: every consumed instruction is compared with the next expected PC.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid && sb_q.size() != 0) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            check("sb_pc",    instr_pc, e);
            check("sb_instr", instr_out, mem_word(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h4,  1'b1, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8};

        #3;
        // Zero-wait streaming, then back-pressure filling the buffer.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].new_reset) do_reset(tbl[i].ready);
            next_cycle();
            instr_ready = tbl[i].ready;
            @(negedge clk);
            check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
                check($sformatf("tbl%0d_instr", i), instr_out, mem_word(tbl[i].exp_pc));
            end
        end

        // Three wait states: each address held four cycles, one delivery per four cycles.
        wait_states = 3;
        do_reset(1'b1);
        for (int p = 0; p < 4; p++) sb_q.push_back(32'(p * 4));
        nvalid = 0;
        for (int k = 1; k <= 17; k++) begin
            next_cycle();
            @(negedge clk);
            if (instr_valid) nvalid++;
            if (k <= 16) check($sformatf("ws_addr_k%0d", k), imem_addr, 32'(((k - 1) / 4) * 4));
        end
        check("ws_deliveries", 32'(nvalid), 32'd4);
        wait_drain(8);
        wait_states = 0;

        // Redirect while the request for 8 is stalled: response for 8 dropped.
        do_reset(1'b1);
        sb_q.push_back(32'h0);
        next_cycle();
        next_cycle();
        mem_stall = 1'b1;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check("rd_pending_addr", imem_addr, 32'h8);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_flush_valid", 32'(instr_valid), 32'h0);
        check("rd_hold_req",    32'(imem_req), 32'h1);
        check("rd_hold_addr0",  imem_addr, 32'h8);
        next_cycle();
        @(negedge clk);
        check("rd_hold_addr1", imem_addr, 32'h8);
        mem_stall = 1'b0;
        sb_q.push_back(32'h100);
        sb_q.push_back(32'h104);
        next_cycle();
        @(negedge clk);
        check("rd_drop_addr", imem_addr, 32'h8);
        next_cycle();
        @(negedge clk);
        check("rd_new_addr", imem_addr, 32'h100);
        wait_drain(20);

        // Redirect coinciding with an ack: the acked word is discarded, low bits cleared.
        do_reset(1'b1);
        sb_q.push_back(32'h200);
        sb_q.push_back(32'h204);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("ra_addr",  imem_addr, 32'h200);
        check("ra_valid", 32'(instr_valid), 32'h0);
        wait_drain(20);

        // PC wraps modulo 2^32.
        do_reset(1'b1);
        sb_q.push_back(32'hFFFF_FFF8);
        sb_q.push_back(32'hFFFF_FFFC);
        sb_q.push_back(32'h0000_0000);
        sb_q.push_back(32'h0000_0004);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        wait_drain(20);

        // Asynchronous reset with a full buffer, then restart from the reset PC.
        do_reset(1'b0);
        repeat (4) next_cycle();
        @(negedge clk);
        check("full_valid", 32'(instr_valid), 32'h1);
        check("full_req",   32'(imem_req), 32'h0);
        next_cycle();
        do_reset(1'b1);
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        next_cycle();
        @(negedge clk);
        check("rr_req",  32'(imem_req), 32'h1);
        check("rr_addr", imem_addr, 32'h0);
        wait_drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
